sram_axil_resp: RTL and testbench
=================================

Name: sram_axil_resp

Overview:
- Data-memory responder: the slave end of the CPU load/store memory interface.
- Replaces the zero-latency combinational PMEM model with an AXI4-Lite-style handshaked SRAM that has programmable response latency.
- Serves the LSU master. Independent read channel (AR/R) and write channel (AW/W/B) share one word-addressed storage array.
- Lets the pipeline and LSU be exercised against multi-cycle memory.

Parameters:
- ADDR_W, 32: address width.
- DEPTH, 1024: storage size in 32-bit words; power of two.
- BASE, 32'h8000_0000: byte address of word 0.
- LATENCY, 1: cycles from request accept to response valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- araddr  in  ADDR_W  read byte address.
- arvalid  in  1  read request valid.
- arready  out  1  read request accepted when high with arvalid.
- rdata  out  32  read word.
- rresp  out  2  2'b00 OKAY, 2'b11 DECERR.
- rvalid  out  1  read response valid.
- rready  in  1  master accepts read response.
- awaddr  in  ADDR_W  write byte address.
- awvalid  in  1  write address valid.
- awready  out  1  write address accepted.
- wdata  in  32  write word.
- wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
- wvalid  in  1  write data valid.
- wready  out  1  write data accepted.
- bresp  out  2  write response code, same encoding as rresp.
- bvalid  out  1  write response valid.
- bready  in  1  master accepts write response.

Behaviour:
- Reset (rst=0, async): read FSM R_IDLE, write FSM W_IDLE, counters 0.
  - Outputs during/after reset: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
  - Storage is not cleared.
  - Reset mid-transaction aborts it; a pending write is not committed.
- Address decode: index=(addr-BASE)>>2; addr[1:0] ignored. In range iff BASE <= addr < BASE+4*DEPTH; otherwise DECERR.
- Read FSM (R_IDLE -> R_WAIT -> R_RESP -> R_IDLE):
  - arready = (state==R_IDLE). Accept on arvalid&arready: latch address, cnt <= LATENCY-1, go to R_WAIT.
  - In R_WAIT, cnt decrements each cycle. At cnt==0, sample storage into rdata (or 0 with DECERR) and go to R_RESP.
  - rvalid rises exactly LATENCY cycles after the accept edge.
  - R_RESP: rvalid=1; rdata/rresp held stable until rvalid&rready, then R_IDLE.
  - Next AR is accepted no earlier than the cycle after the handshake.
- Write FSM (W_IDLE -> W_WAIT -> W_RESP -> W_IDLE):
  - awready=1 until AW is captured; wready=1 until W is captured.
  - AW and W may arrive in either order or in the same cycle.
  - When both are captured, cnt <= LATENCY-1 and go to W_WAIT.
  - At cnt==0: commit bytes where wstrb=1 (DECERR: no commit), set bresp, go to W_RESP.
  - W_RESP: bvalid=1 held until bready, then W_IDLE with awready=wready=1.
- Collision: read sample and write commit on the same edge, same index -> read returns the pre-write data.
- wstrb=4'b0000 in range: OKAY, storage unchanged.
- rready/bready may be held high in advance; the response then completes in its first valid cycle.

Optional Feature:
- SRAM_RAND_DELAY_EN defined:
  - A 4-bit LFSR (x^4+x^3+1, reset seed 4'b1001) advances every cycle.
  - On each accept, cnt loads lfsr[3:0] (when nonzero) or LATENCY-1 (when zero); read and write sample it independently.
  - Effective latency is 1..16 cycles.
- SRAM_RAND_DELAY_EN undefined: fixed LATENCY; no LFSR logic.

Test Plan:
- LATENCY=1: write 0xDEADBEEF to 0x8000_0010 (wstrb=4'hF), then read 0x8000_0010 -> bvalid 1 cycle after AW/W capture, bresp=00; rvalid 1 cycle after AR accept, rdata=0xDEADBEEF, rresp=00.
- Byte strobe: preload 0x11223344 at 0x8000_0020, write 0xAABBCCDD with wstrb=4'b0101 -> read returns 0x11BB33DD.
- AW and W separation: AW at cycle 2, W at cycle 5 -> awready low from cycle 3; W_WAIT entered after cycle-5 edge; bvalid one cycle later.
- Backpressure: LATENCY=3 read with rready held 0 for 4 cycles -> rvalid rises 3 cycles after accept; rdata stable; arready=0 until cycle after rready=1.
- Decode error: read 0x7FFF_FFFC and write 0x8000_1000 (DEPTH=1024) -> rresp=bresp=2'b11, rdata=0, storage unchanged.
- Reset mid-write: drop rst during W_WAIT -> bvalid=0, arready=awready=wready=1 immediately; target word keeps its old value on later read.

Source files
------------

// File: rtl/sram_axil_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_axil_resp: AXI4-Lite-style word SRAM responder with programmable latency.
// Optional `SRAM_RAND_DELAY_EN: LFSR-randomised response latency. Rev 1.0
// ---------------------------------------------------------------------------
module sram_axil_resp #(
  parameter int          ADDR_W  = 32,
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int                IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(4 * DEPTH);
  localparam logic [3:0]        LAT_M1 = 4'(LATENCY - 1);
  localparam logic [1:0]        OKAY   = 2'b00;
  localparam logic [1:0]        DECERR = 2'b11;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [31:0] mem [DEPTH];

  logic [1:0]        rd_state;
  logic [3:0]        rd_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        wr_state;
  logic [3:0]        wr_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              aw_got;
  logic              w_got;
  logic [3:0]        rd_load;
  logic [3:0]        wr_load;

`ifdef SRAM_RAND_DELAY_EN
  logic [3:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 4'b1001;
    else      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  end

  assign rd_load = (lfsr != 4'd0) ? lfsr : LAT_M1;
  assign wr_load = (lfsr != 4'd0) ? lfsr : LAT_M1;
`else
  assign rd_load = LAT_M1;
  assign wr_load = LAT_M1;
`endif

  // Decode checks the lower bound separately so wrap-around offsets are rejected.
  logic [ADDR_W-1:0] rd_off;
  logic [ADDR_W-1:0] wr_off;
  logic              rd_ok;
  logic              wr_ok;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_commit;
  logic              aw_have;
  logic              w_have;

  assign rd_off    = rd_addr - BASE_A;
  assign wr_off    = wr_addr - BASE_A;
  assign rd_ok     = (rd_addr >= BASE_A) && (rd_off < SPAN);
  assign wr_ok     = (wr_addr >= BASE_A) && (wr_off < SPAN);
  assign rd_idx    = rd_off[IDX_W+1:2];
  assign wr_idx    = wr_off[IDX_W+1:2];
  assign wr_commit = (wr_state == W_WAIT) && (wr_cnt == 4'd0) && wr_ok;

  assign arready = (rd_state == R_IDLE);
  assign rvalid  = (rd_state == R_RESP);
  assign awready = (wr_state == W_IDLE) && !aw_got;
  assign wready  = (wr_state == W_IDLE) && !w_got;
  assign bvalid  = (wr_state == W_RESP);
  assign aw_have = aw_got || awvalid;
  assign w_have  = w_got || wvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      rd_cnt   <= 4'd0;
      rd_addr  <= '0;
      rdata    <= 32'd0;
      rresp    <= OKAY;
    end else begin
      case (rd_state)
        R_IDLE: if (arvalid) begin
          rd_addr  <= araddr;
          rd_cnt   <= rd_load;
          rd_state <= R_WAIT;
        end
        R_WAIT: if (rd_cnt == 4'd0) begin
          rdata    <= rd_ok ? mem[rd_idx] : 32'd0;
          rresp    <= rd_ok ? OKAY : DECERR;
          rd_state <= R_RESP;
        end else begin
          rd_cnt <= rd_cnt - 4'd1;
        end
        R_RESP: if (rready) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= W_IDLE;
      wr_cnt   <= 4'd0;
      wr_addr  <= '0;
      wr_data  <= 32'd0;
      wr_strb  <= 4'd0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      bresp    <= OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (awvalid && !aw_got) wr_addr <= awaddr;
          if (wvalid && !w_got) begin
            wr_data <= wdata;
            wr_strb <= wstrb;
          end
          if (aw_have && w_have) begin
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            wr_cnt   <= wr_load;
            wr_state <= W_WAIT;
          end else begin
            aw_got <= aw_have;
            w_got  <= w_have;
          end
        end
        W_WAIT: if (wr_cnt == 4'd0) begin
          bresp    <= wr_ok ? OKAY : DECERR;
          wr_state <= W_RESP;
        end else begin
          wr_cnt <= wr_cnt - 4'd1;
        end
        W_RESP: if (bready) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Storage is never reset; a same-edge read sample sees the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_axil_resp.sv
`default_nettype none
// Directed bench for sram_axil_resp: a LATENCY=1 instance and a LATENCY=3 instance.
module tb_sram_axil_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [3:0]  wstrb = '0;
  logic [1:0]  rresp, bresp;

  logic [31:0] l3_araddr = '0, l3_awaddr = '0, l3_wdata = '0, l3_rdata;
  logic        l3_arvalid = 1'b0, l3_rready = 1'b0, l3_awvalid = 1'b0, l3_wvalid = 1'b0, l3_bready = 1'b0;
  logic        l3_arready, l3_rvalid, l3_awready, l3_wready, l3_bvalid;
  logic [3:0]  l3_wstrb = '0;
  logic [1:0]  l3_rresp, l3_bresp;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_axil_resp dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  sram_axil_resp #(.LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .araddr(l3_araddr), .arvalid(l3_arvalid), .arready(l3_arready),
    .rdata(l3_rdata), .rresp(l3_rresp), .rvalid(l3_rvalid), .rready(l3_rready),
    .awaddr(l3_awaddr), .awvalid(l3_awvalid), .awready(l3_awready),
    .wdata(l3_wdata), .wstrb(l3_wstrb), .wvalid(l3_wvalid), .wready(l3_wready),
    .bresp(l3_bresp), .bvalid(l3_bvalid), .bready(l3_bready)
  );

  // Stimulus drivers: lat counts cycles from the capture edge to response valid.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat, output logic [1:0] resp);
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; lat = 0;
    while (!bvalid && lat < 40) begin @(negedge clk); lat++; end
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] d,
                         output logic [1:0] resp);
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; lat = 0;
    while (!rvalid && lat < 40) begin @(negedge clk); lat++; end
    d = rdata; resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] ctrl;
    repeat (2) @(negedge clk);
    ctrl = {arready, awready, wready, rvalid, bvalid, rresp[0] | bresp[0], rresp[1] | bresp[1]};
    vectors++;
    if (ctrl !== 7'b1110000) begin miscompares++;
      $display("FAIL reset_ctrl: got %b expected 1110000", ctrl); end
    vectors++;
    if (rdata !== 32'd0) begin miscompares++;
      $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] d; logic [1:0] r;
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, lat, r);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL basic_wlat: got %0d expected 1", lat); end
    vectors++;
    if (r !== 2'b00) begin miscompares++; $display("FAIL basic_bresp: got %b expected 00", r); end
    do_read(32'h8000_0010, lat, d, r);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL basic_rlat: got %0d expected 1", lat); end
    vectors++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin miscompares++;
      $display("FAIL basic_rdata: got %h/%b expected deadbeef/00", d, r); end
  endtask

  task automatic test_strobe();
    int lat; logic [31:0] d; logic [1:0] r;
    do_write(32'h8000_0020, 32'h1122_3344, 4'hF, lat, r);
    do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, lat, r);
    do_read(32'h8000_0020, lat, d, r);
    vectors++;
    if (d !== 32'h11BB_33DD) begin miscompares++;
      $display("FAIL strobe_merge: got %h expected 11bb33dd", d); end
    do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, lat, r);
    vectors++;
    if (r !== 2'b00) begin miscompares++; $display("FAIL strobe_zero_bresp: got %b expected 00", r); end
    do_read(32'h8000_0020, lat, d, r);
    vectors++;
    if (d !== 32'h11BB_33DD) begin miscompares++;
      $display("FAIL strobe_zero_data: got %h expected 11bb33dd", d); end
  endtask

  task automatic test_aw_w_split();
    int lat; logic [31:0] d; logic [1:0] r;
    @(negedge clk);
    awaddr = 32'h8000_0030; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    vectors++;
    if ({awready, wready} !== 2'b01) begin miscompares++;
      $display("FAIL split_aw_held: got %b expected 01", {awready, wready}); end
    repeat (2) @(negedge clk);
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    vectors++;
    if ({awready, wready, bvalid} !== 3'b010) begin miscompares++;
      $display("FAIL split_wait_w: got %b expected 010", {awready, wready, bvalid}); end
    @(negedge clk);
    wvalid = 1'b0;
    vectors++;
    if ({awready, wready, bvalid} !== 3'b000) begin miscompares++;
      $display("FAIL split_in_wait: got %b expected 000", {awready, wready, bvalid}); end
    @(negedge clk);
    vectors++;
    if ({bvalid, bresp} !== 3'b100) begin miscompares++;
      $display("FAIL split_bvalid: got %b expected 100", {bvalid, bresp}); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    vectors++;
    if ({awready, wready, bvalid} !== 3'b110) begin miscompares++;
      $display("FAIL split_idle: got %b expected 110", {awready, wready, bvalid}); end
    // W ahead of AW
    wdata = 32'h0F0E_0D0C; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    vectors++;
    if ({awready, wready} !== 2'b10) begin miscompares++;
      $display("FAIL split_w_first: got %b expected 10", {awready, wready}); end
    awaddr = 32'h8000_0034; awvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bvalid !== 1'b1) begin miscompares++; $display("FAIL split_w_first_b: got %b expected 1", bvalid); end
    @(negedge clk);
    bready = 1'b0;
    do_read(32'h8000_0030, lat, d, r);
    vectors++;
    if (d !== 32'h1234_5678) begin miscompares++; $display("FAIL split_rd30: got %h expected 12345678", d); end
    do_read(32'h8000_0034, lat, d, r);
    vectors++;
    if (d !== 32'h0F0E_0D0C) begin miscompares++; $display("FAIL split_rd34: got %h expected 0f0e0d0c", d); end
  endtask

  task automatic test_collision();
    int lat; logic [31:0] d; logic [1:0] r;
    @(negedge clk);
    araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h8000_0010; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rvalid, bvalid} !== 2'b11 || rdata !== 32'hDEAD_BEEF) begin miscompares++;
      $display("FAIL collision_old: got %b/%h expected 11/deadbeef", {rvalid, bvalid}, rdata); end
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    do_read(32'h8000_0010, lat, d, r);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL collision_new: got %h expected 00000000", d); end
  endtask

  task automatic test_decerr();
    int lat; logic [31:0] d; logic [1:0] r;
    do_write(32'h8000_0000, 32'h0102_0304, 4'hF, lat, r);
    do_write(32'h8000_0FFC, 32'h55AA_55AA, 4'hF, lat, r);
    vectors++;
    if (r !== 2'b00) begin miscompares++; $display("FAIL dec_top_bresp: got %b expected 00", r); end
    do_read(32'h7FFF_FFFC, lat, d, r);
    vectors++;
    if (r !== 2'b11 || d !== 32'h0) begin miscompares++;
      $display("FAIL dec_low_read: got %b/%h expected 11/00000000", r, d); end
    do_write(32'h8000_1000, 32'hCAFE_F00D, 4'hF, lat, r);
    vectors++;
    if (r !== 2'b11) begin miscompares++; $display("FAIL dec_high_bresp: got %b expected 11", r); end
    do_read(32'h8000_1000, lat, d, r);
    vectors++;
    if (r !== 2'b11 || d !== 32'h0) begin miscompares++;
      $display("FAIL dec_high_read: got %b/%h expected 11/00000000", r, d); end
    do_read(32'h8000_0000, lat, d, r);
    vectors++;
    if (r !== 2'b00 || d !== 32'h0102_0304) begin miscompares++;
      $display("FAIL dec_word0_kept: got %b/%h expected 00/01020304", r, d); end
    do_read(32'h8000_0FFC, lat, d, r);
    vectors++;
    if (d !== 32'h55AA_55AA) begin miscompares++; $display("FAIL dec_top_word: got %h expected 55aa55aa", d); end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    l3_awaddr = 32'h8000_0040; l3_wdata = 32'h0BAD_CAFE; l3_wstrb = 4'hF;
    l3_awvalid = 1'b1; l3_wvalid = 1'b1; l3_bready = 1'b1;
    @(negedge clk);
    l3_awvalid = 1'b0; l3_wvalid = 1'b0; lat = 0;
    while (!l3_bvalid && lat < 40) begin @(negedge clk); lat++; end
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL bp_wlat: got %0d expected 3", lat); end
    @(negedge clk);
    l3_bready = 1'b0;
    l3_araddr = 32'h8000_0040; l3_arvalid = 1'b1; l3_rready = 1'b0;
    @(negedge clk);
    l3_arvalid = 1'b0;
    vectors++;
    if ({l3_arready, l3_rvalid} !== 2'b00) begin miscompares++;
      $display("FAIL bp_accepted: got %b expected 00", {l3_arready, l3_rvalid}); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      vectors++;
      if (l3_rvalid !== (c == 3)) begin miscompares++;
        $display("FAIL bp_rvalid_c%0d: got %b expected %b", c, l3_rvalid, c == 3); end
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      vectors++;
      if ({l3_rvalid, l3_arready} !== 2'b10 || l3_rdata !== 32'h0BAD_CAFE) begin miscompares++;
        $display("FAIL bp_hold_%0d: got %b/%h expected 10/0badcafe", k, {l3_rvalid, l3_arready}, l3_rdata); end
    end
    l3_rready = 1'b1;
    @(negedge clk);
    l3_rready = 1'b0;
    vectors++;
    if ({l3_rvalid, l3_arready} !== 2'b01) begin miscompares++;
      $display("FAIL bp_release: got %b expected 01", {l3_rvalid, l3_arready}); end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [31:0] d; logic [1:0] r;
    do_write(32'h8000_0050, 32'h1357_9BDF, 4'hF, lat, r);
    @(negedge clk);
    awaddr = 32'h8000_0050; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if ({bvalid, arready, awready, wready} !== 4'b0111) begin miscompares++;
      $display("FAIL rst_mid_ctrl: got %b expected 0111", {bvalid, arready, awready, wready}); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bvalid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_bvalid: got %b expected 0", bvalid); end
    do_read(32'h8000_0050, lat, d, r);
    vectors++;
    if (d !== 32'h1357_9BDF) begin miscompares++; $display("FAIL rst_mid_kept: got %h expected 13579bdf", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_aw_w_split();
    test_collision();
    test_decerr();
    test_backpressure();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
